// File: rtl/xmm_writeback_scheduler_if.sv
// Producer/consumer bundle for the XMM write-back scheduler: three result
// channels in, one register-file write port plus mux operands out.
interface xmm_writeback_scheduler_if #(
    parameter int unsigned XMM_ADDR_WIDTH = 3
);
    logic                      alu_valid;
    logic                      alu_ready;
    logic [1:0]                alu_fmt;
    logic [XMM_ADDR_WIDTH-1:0] alu_addr;
    logic [31:0]               alu_data;

    logic                      mem_valid;
    logic                      mem_ready;
    logic [XMM_ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]               mem_data;

    logic                      fpu_valid;
    logic                      fpu_ready;
    logic [XMM_ADDR_WIDTH-1:0] fpu_addr;
    logic [63:0]               fpu_data;

    logic                      xmm_write_en;
    logic [XMM_ADDR_WIDTH-1:0] xmm_write_addr;
    logic [2:0]                xmm_src;
    logic [31:0]               xmm_alu_res;
    logic [31:0]               xmm_mem_read_data;
    logic [63:0]               xmm_fpu_res;
    logic                      err_illegal_fmt;
    logic                      busy;

    // Producer / register-file side.
    modport master (
        output alu_valid, alu_fmt, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output fpu_valid, fpu_addr, fpu_data,
        input  alu_ready, mem_ready, fpu_ready,
        input  xmm_write_en, xmm_write_addr, xmm_src,
        input  xmm_alu_res, xmm_mem_read_data, xmm_fpu_res,
        input  err_illegal_fmt, busy
    );

    // Scheduler side.
    modport slave (
        input  alu_valid, alu_fmt, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  fpu_valid, fpu_addr, fpu_data,
        output alu_ready, mem_ready, fpu_ready,
        output xmm_write_en, xmm_write_addr, xmm_src,
        output xmm_alu_res, xmm_mem_read_data, xmm_fpu_res,
        output err_illegal_fmt, busy
    );
endinterface

// File: rtl/xmm_writeback_scheduler.sv
// Arbitrates the single XMM register-file write port between ALU, MEM and FPU
// one-entry slots. Optional anti-starvation aging: XMM_WB_STARVE_GUARD_EN.
module xmm_writeback_scheduler #(
    parameter int unsigned XMM_ADDR_WIDTH = 3,
    parameter int unsigned STARVE_LIMIT   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    xmm_writeback_scheduler_if.slave        bus
);
    localparam int unsigned AW          = XMM_ADDR_WIDTH;
    localparam logic [2:0]  SRC_NONE    = 3'b000;
    localparam logic [2:0]  SRC_MEM     = 3'b100;
    localparam logic [2:0]  SRC_FPU     = 3'b110;
    localparam logic [1:0]  FMT_ILLEGAL = 2'b11;

    // Elaboration guard on the aging threshold range.
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be within 1..255");
    end

    logic          alu_full_q;
    logic [AW-1:0] alu_addr_q;
    logic [1:0]    alu_fmt_q;
    logic [31:0]   alu_data_q;

    logic          mem_full_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_data_q;

    logic          fpu_full_q;
    logic [AW-1:0] fpu_addr_q;
    logic [63:0]   fpu_data_q;

    logic          err_illegal_q;

    logic          grant_alu;
    logic          grant_mem;
    logic          grant_fpu;

    logic          alu_ready_c;
    logic          mem_ready_c;
    logic          fpu_ready_c;

    logic          alu_accept;
    logic          mem_accept;
    logic          fpu_accept;
    logic          alu_fmt_legal;

`ifdef XMM_WB_STARVE_GUARD_EN
    localparam int unsigned       CNT_W = 8;
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] alu_wait_q;
    logic [CNT_W-1:0] mem_wait_q;
    logic [CNT_W-1:0] fpu_wait_q;
    logic             alu_starved;
    logic             mem_starved;
    logic             fpu_starved;

    // Wait counter: clears when empty or granted, otherwise saturates at LIMIT.
    function automatic logic [CNT_W-1:0] wait_next(
        input logic             full,
        input logic             granted,
        input logic [CNT_W-1:0] cnt
    );
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (!full || granted) begin
            nxt = '0;
        end else if (cnt != LIMIT) begin
            nxt = cnt + CNT_W'(1);
        end
        return nxt;
    endfunction

    assign alu_starved = alu_full_q && (alu_wait_q == LIMIT);
    assign mem_starved = mem_full_q && (mem_wait_q == LIMIT);
    assign fpu_starved = fpu_full_q && (fpu_wait_q == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_wait_q <= '0;
            mem_wait_q <= '0;
            fpu_wait_q <= '0;
        end else begin
            alu_wait_q <= wait_next(alu_full_q, grant_alu, alu_wait_q);
            mem_wait_q <= wait_next(mem_full_q, grant_mem, mem_wait_q);
            fpu_wait_q <= wait_next(fpu_full_q, grant_fpu, fpu_wait_q);
        end
    end

    // Starved slots first, then fixed FPU > MEM > ALU order within each class.
    always_comb begin
        grant_fpu = 1'b0;
        grant_mem = 1'b0;
        grant_alu = 1'b0;
        if (fpu_starved) begin
            grant_fpu = 1'b1;
        end else if (mem_starved) begin
            grant_mem = 1'b1;
        end else if (alu_starved) begin
            grant_alu = 1'b1;
        end else if (fpu_full_q) begin
            grant_fpu = 1'b1;
        end else if (mem_full_q) begin
            grant_mem = 1'b1;
        end else if (alu_full_q) begin
            grant_alu = 1'b1;
        end
    end
`else
    // Pure fixed priority FPU > MEM > ALU.
    always_comb begin
        grant_fpu = 1'b0;
        grant_mem = 1'b0;
        grant_alu = 1'b0;
        if (fpu_full_q) begin
            grant_fpu = 1'b1;
        end else if (mem_full_q) begin
            grant_mem = 1'b1;
        end else if (alu_full_q) begin
            grant_alu = 1'b1;
        end
    end
`endif

    // Ready is a function of slot state only; a granted slot passes through.
    assign alu_ready_c = !reset && (!alu_full_q || grant_alu);
    assign mem_ready_c = !reset && (!mem_full_q || grant_mem);
    assign fpu_ready_c = !reset && (!fpu_full_q || grant_fpu);

    assign alu_accept    = bus.alu_valid && alu_ready_c;
    assign mem_accept    = bus.mem_valid && mem_ready_c;
    assign fpu_accept    = bus.fpu_valid && fpu_ready_c;
    assign alu_fmt_legal = (bus.alu_fmt != FMT_ILLEGAL);

    // ALU slot; an illegal-format result is consumed without filling the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_full_q    <= 1'b0;
            alu_addr_q    <= '0;
            alu_fmt_q     <= '0;
            alu_data_q    <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            if (alu_accept) begin
                alu_full_q <= alu_fmt_legal;
            end else if (grant_alu) begin
                alu_full_q <= 1'b0;
            end
            if (alu_accept && alu_fmt_legal) begin
                alu_addr_q <= bus.alu_addr;
                alu_fmt_q  <= bus.alu_fmt;
                alu_data_q <= bus.alu_data;
            end
            err_illegal_q <= alu_accept && !alu_fmt_legal;
        end
    end

    // MEM slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_full_q <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            if (mem_accept) begin
                mem_full_q <= 1'b1;
                mem_addr_q <= bus.mem_addr;
                mem_data_q <= bus.mem_data;
            end else if (grant_mem) begin
                mem_full_q <= 1'b0;
            end
        end
    end

    // FPU slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpu_full_q <= 1'b0;
            fpu_addr_q <= '0;
            fpu_data_q <= '0;
        end else begin
            if (fpu_accept) begin
                fpu_full_q <= 1'b1;
                fpu_addr_q <= bus.fpu_addr;
                fpu_data_q <= bus.fpu_data;
            end else if (grant_fpu) begin
                fpu_full_q <= 1'b0;
            end
        end
    end

    // Write-port drive from the single granted slot; ALU src code is {0, fmt}.
    always_comb begin
        bus.xmm_write_en   = 1'b0;
        bus.xmm_write_addr = '0;
        bus.xmm_src        = SRC_NONE;
        if (grant_fpu) begin
            bus.xmm_write_en   = 1'b1;
            bus.xmm_write_addr = fpu_addr_q;
            bus.xmm_src        = SRC_FPU;
        end else if (grant_mem) begin
            bus.xmm_write_en   = 1'b1;
            bus.xmm_write_addr = mem_addr_q;
            bus.xmm_src        = SRC_MEM;
        end else if (grant_alu) begin
            bus.xmm_write_en   = 1'b1;
            bus.xmm_write_addr = alu_addr_q;
            bus.xmm_src        = {1'b0, alu_fmt_q};
        end
    end

    assign bus.alu_ready         = alu_ready_c;
    assign bus.mem_ready         = mem_ready_c;
    assign bus.fpu_ready         = fpu_ready_c;
    assign bus.xmm_alu_res       = alu_data_q;
    assign bus.xmm_mem_read_data = mem_data_q;
    assign bus.xmm_fpu_res       = fpu_data_q;
    assign bus.err_illegal_fmt   = err_illegal_q;
    assign bus.busy              = alu_full_q || mem_full_q || fpu_full_q;

endmodule

// File: tb/tb_xmm_writeback_scheduler.sv
// Directed bench for xmm_writeback_scheduler; starvation expectations follow
// XMM_WB_STARVE_GUARD_EN with STARVE_LIMIT=4.
module tb_xmm_writeback_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    xmm_writeback_scheduler_if #(.XMM_ADDR_WIDTH(3)) bus ();

    xmm_writeback_scheduler #(
        .XMM_ADDR_WIDTH(3),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_fmt = 2'b00; bus.alu_addr = 3'd0; bus.alu_data = 32'h0;
        bus.mem_valid = 1'b0; bus.mem_addr = 3'd0; bus.mem_data = 32'h0;
        bus.fpu_valid = 1'b0; bus.fpu_addr = 3'd0; bus.fpu_data = 64'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        tests_run++;
        if (bus.xmm_write_en !== 1'b0 || bus.xmm_src !== 3'b000 || bus.xmm_write_addr !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_write: en=%b src=%b addr=%0d required 0/000/0", bus.xmm_write_en, bus.xmm_src, bus.xmm_write_addr);
        end
        tests_run++;
        if (bus.xmm_alu_res !== 32'h0 || bus.xmm_mem_read_data !== 32'h0 || bus.xmm_fpu_res !== 64'h0 ||
            bus.err_illegal_fmt !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_data: alu=%h mem=%h fpu=%h err=%b busy=%b required all 0", bus.xmm_alu_res,
                     bus.xmm_mem_read_data, bus.xmm_fpu_res, bus.err_illegal_fmt, bus.busy);
        end
        tests_run++;
        if ({bus.alu_ready, bus.mem_ready, bus.fpu_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ready_held: got %b required 000", {bus.alu_ready, bus.mem_ready, bus.fpu_ready});
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if ({bus.alu_ready, bus.mem_ready, bus.fpu_ready} !== 3'b111 || bus.xmm_write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b en=%b required 111/0", {bus.alu_ready, bus.mem_ready, bus.fpu_ready}, bus.xmm_write_en);
        end
    endtask

    task automatic test_single_alu();
        bus.alu_valid = 1'b1; bus.alu_fmt = 2'b01; bus.alu_addr = 3'd5; bus.alu_data = 32'hFFFF_FFFF;
        tick();
        bus.alu_valid = 1'b0;
        tests_run++;
        if (bus.xmm_write_en !== 1'b1 || bus.xmm_write_addr !== 3'd5 || bus.xmm_src !== 3'b001 ||
            bus.xmm_alu_res !== 32'hFFFF_FFFF || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_alu_write: en=%b addr=%0d src=%b res=%h busy=%b required 1/5/001/ffffffff/1",
                     bus.xmm_write_en, bus.xmm_write_addr, bus.xmm_src, bus.xmm_alu_res, bus.busy);
        end
        tick();
        tests_run++;
        if (bus.xmm_write_en !== 1'b0 || bus.busy !== 1'b0 || bus.xmm_alu_res !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL single_alu_after: en=%b busy=%b res=%h required 0/0/ffffffff",
                     bus.xmm_write_en, bus.busy, bus.xmm_alu_res);
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_src  [3];
        logic [2:0] exp_addr [3];
        exp_src  = '{3'b110, 3'b100, 3'b010};
        exp_addr = '{3'd1, 3'd2, 3'd3};
        bus.fpu_valid = 1'b1; bus.fpu_addr = 3'd1; bus.fpu_data = 64'h0000_0000_0000_000C;
        bus.mem_valid = 1'b1; bus.mem_addr = 3'd2; bus.mem_data = 32'h0000_000B;
        bus.alu_valid = 1'b1; bus.alu_fmt = 2'b10; bus.alu_addr = 3'd3; bus.alu_data = 32'h0000_000A;
        tick();
        idle_inputs();
        tests_run++;
        if ({bus.alu_ready, bus.mem_ready, bus.fpu_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL sim_ready: got %b required 001", {bus.alu_ready, bus.mem_ready, bus.fpu_ready});
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (bus.xmm_write_en !== 1'b1 || bus.xmm_src !== exp_src[i] || bus.xmm_write_addr !== exp_addr[i] ||
                bus.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL sim_write%0d: en=%b src=%b addr=%0d busy=%b required 1/%b/%0d/1", i,
                         bus.xmm_write_en, bus.xmm_src, bus.xmm_write_addr, bus.busy, exp_src[i], exp_addr[i]);
            end
            tick();
        end
        tests_run++;
        if (bus.xmm_write_en !== 1'b0 || bus.busy !== 1'b0 || bus.xmm_fpu_res !== 64'hC ||
            bus.xmm_mem_read_data !== 32'hB || bus.xmm_alu_res !== 32'hA) begin
            tests_failed++;
            $display("FAIL sim_drained: en=%b busy=%b fpu=%h mem=%h alu=%h required 0/0/c/b/a", bus.xmm_write_en,
                     bus.busy, bus.xmm_fpu_res, bus.xmm_mem_read_data, bus.xmm_alu_res);
        end
    endtask

    task automatic test_back_to_back();
        bus.fpu_valid = 1'b1;
        bus.fpu_addr  = 3'd4;
        for (int i = 1; i <= 4; i++) begin
            bus.fpu_data = 64'(i);
            tests_run++;
            if (bus.fpu_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_ready%0d: got %b required 1", i, bus.fpu_ready);
            end
            tick();
            tests_run++;
            if (bus.xmm_write_en !== 1'b1 || bus.xmm_src !== 3'b110 || bus.xmm_write_addr !== 3'd4 ||
                bus.xmm_fpu_res !== 64'(i)) begin
                tests_failed++;
                $display("FAIL b2b_write%0d: en=%b src=%b addr=%0d res=%h required 1/110/4/%h", i,
                         bus.xmm_write_en, bus.xmm_src, bus.xmm_write_addr, bus.xmm_fpu_res, 64'(i));
            end
        end
        bus.fpu_valid = 1'b0;
        tick();
        tests_run++;
        if (bus.xmm_write_en !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: en=%b busy=%b required 0/0", bus.xmm_write_en, bus.busy);
        end
    endtask

    task automatic test_illegal_fmt();
        bus.alu_valid = 1'b1; bus.alu_fmt = 2'b11; bus.alu_addr = 3'd6; bus.alu_data = 32'h0000_1234;
        tick();
        idle_inputs();
        tests_run++;
        if (bus.xmm_write_en !== 1'b0 || bus.err_illegal_fmt !== 1'b1 || bus.busy !== 1'b0 ||
            bus.xmm_alu_res !== 32'hA) begin
            tests_failed++;
            $display("FAIL illegal_accept: en=%b err=%b busy=%b res=%h required 0/1/0/a", bus.xmm_write_en,
                     bus.err_illegal_fmt, bus.busy, bus.xmm_alu_res);
        end
        tick();
        tests_run++;
        if (bus.err_illegal_fmt !== 1'b0 || bus.xmm_write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_pulse: err=%b en=%b required 0/0", bus.err_illegal_fmt, bus.xmm_write_en);
        end
    endtask

    task automatic test_reset_mid_traffic();
        bus.fpu_valid = 1'b1; bus.fpu_addr = 3'd1; bus.fpu_data = 64'h77;
        bus.mem_valid = 1'b1; bus.mem_addr = 3'd2; bus.mem_data = 32'h66;
        bus.alu_valid = 1'b1; bus.alu_fmt = 2'b00; bus.alu_addr = 3'd3; bus.alu_data = 32'h55;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        tests_run++;
        if (bus.xmm_write_en !== 1'b0 || bus.busy !== 1'b0 || bus.xmm_fpu_res !== 64'h0) begin
            tests_failed++;
            $display("FAIL midreset_held: en=%b busy=%b fpu=%h required 0/0/0", bus.xmm_write_en, bus.busy, bus.xmm_fpu_res);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if ({bus.alu_ready, bus.mem_ready, bus.fpu_ready} !== 3'b111 || bus.xmm_write_en !== 1'b0 ||
            bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_release: ready=%b en=%b busy=%b required 111/0/0",
                     {bus.alu_ready, bus.mem_ready, bus.fpu_ready}, bus.xmm_write_en, bus.busy);
        end
    endtask

    task automatic test_starvation();
        int first_alu = 0;
        bus.alu_valid = 1'b1; bus.alu_fmt = 2'b00; bus.alu_addr = 3'd7; bus.alu_data = 32'h55;
        bus.mem_valid = 1'b1; bus.mem_addr = 3'd2; bus.mem_data = 32'h99;
        tick();
        bus.alu_valid = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (first_alu == 0 && bus.xmm_write_en === 1'b1 && bus.xmm_src === 3'b000 &&
                bus.xmm_write_addr === 3'd7) begin
                first_alu = cyc;
            end
            if (cyc < 10) tick();
        end
`ifdef XMM_WB_STARVE_GUARD_EN
        tests_run++;
        if (first_alu != 5) begin
            tests_failed++;
            $display("FAIL starve_guard: alu first granted cycle %0d required 5", first_alu);
        end
`else
        tests_run++;
        if (first_alu != 0) begin
            tests_failed++;
            $display("FAIL starve_fixed: alu granted cycle %0d required never (0)", first_alu);
        end
`endif
        bus.mem_valid = 1'b0;
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.xmm_write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL starve_drain: busy=%b en=%b required 0/0", bus.busy, bus.xmm_write_en);
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_back_to_back();
        test_illegal_fmt();
        test_reset_mid_traffic();
        test_starvation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/xmm_writeback_scheduler.md
# xmm_writeback_scheduler

Arbitrates the single XMM register-file write port between three producers: ALU results needing int/fp32-to-Q15 conversion, memory load results, and 64-bit FPU results. Each producer has a one-entry holding slot with a valid/ready handshake. Each cycle the scheduler grants one full slot. It drives the write-data mux select code, the raw operands the mux converts, and the register-file write enable and address.

## Interface
Parameters:
- XMM_ADDR_WIDTH, 3, XMM register index width
- STARVE_LIMIT, 8, wait cycles before a slot is promoted (1..255)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU slot can accept
- alu_fmt  in  2  00 u32, 01 i32, 10 fp32, 11 illegal
- alu_addr  in  XMM_ADDR_WIDTH  destination register
- alu_data  in  32  ALU result
- mem_valid / mem_ready / mem_addr / mem_data  in/out/in/in  1/1/XMM_ADDR_WIDTH/32  load-result channel
- fpu_valid / fpu_ready / fpu_addr / fpu_data  in/out/in/in  1/1/XMM_ADDR_WIDTH/64  FPU-result channel (already Q15)
- xmm_write_en  out  1  register-file write this cycle
- xmm_write_addr  out  XMM_ADDR_WIDTH  destination of granted slot
- xmm_src  out  3  mux select: 000 u32, 001 i32, 010 fp32, 100 mem, 110 fpu
- xmm_alu_res  out  32  ALU slot data
- xmm_mem_read_data  out  32  MEM slot data
- xmm_fpu_res  out  64  FPU slot data
- err_illegal_fmt  out  1  one-cycle pulse when an fmt=11 result is dropped
- busy  out  1  any slot full

## Operation
- Each channel has a slot with full flag, addr, data, and (ALU only) fmt.
- Handshake: transfer on valid && ready at the edge. Payload must be stable while valid && !ready. Valid must not depend on ready.
- ready = !full || granted_this_cycle (pass-through). It is a combinational function of slot state only, with no path from valid.
- Grant is combinational from slot registers. Fixed order: FPU > MEM > ALU.
- Granted slot: xmm_write_en=1, xmm_write_addr=slot addr, xmm_src=code. The slot clears at the edge unless it is refilled by the same-edge handshake.
- No grant: xmm_write_en=0, xmm_src=000, xmm_write_addr=0.
- Data outputs always equal their slot contents and hold after grant until overwritten. The mux uses only the selected one.
- ALU fmt=11: the result is accepted and the slot is not filled. err_illegal_fmt pulses in the cycle after acceptance.
- No ordering is enforced between channels for the same address. The upstream scoreboard owns WAW hazards.
- Simultaneous accept on all three channels is legal. The slots then drain over 3 cycles.

## Timing
- Latency: accept at edge k → earliest xmm_write_en in cycle k+1 → slot freed at edge k+1.
- Throughput: one write per cycle. Each channel sustains 1/cycle when it is the top-priority full slot.
- Reset (asserted at edge): all slots empty, counters 0.
- Values while reset is held, and in the first cycle after release: xmm_write_en=0, xmm_write_addr=0, xmm_src=000, all data outputs 0, err_illegal_fmt=0, busy=0.
- Ready outputs are 0 while reset is asserted and 1 from the first cycle after release.
- Reset during pending writes discards them. Upstream must not consider them committed.

## Configuration
- XMM_WB_STARVE_GUARD_EN defined:
  - Each slot has an 8-bit wait counter. It increments each cycle the slot is full and not granted, saturating at STARVE_LIMIT, and resets to 0 on grant or when the slot is empty.
  - A slot with counter == STARVE_LIMIT is starved. Starved slots outrank non-starved ones; fixed order breaks ties.
  - Bound: a full ALU slot is granted within STARVE_LIMIT+2 cycles.
- Undefined: pure fixed priority with no counters. ALU may starve under continuous FPU/MEM traffic.

## Test plan
- Reset mid-traffic: fill all slots, assert reset one cycle → next cycle write_en=0, busy=0, and all ready=1 after release.
- Single ALU i32: fmt=01, addr=5, data=0xFFFFFFFF at edge 0 → cycle 1: write_en=1, addr=5, src=001, xmm_alu_res=0xFFFFFFFF. Cycle 2: write_en=0.
- Simultaneous: FPU addr 1, MEM addr 2, ALU fp32 addr 3 on the same edge → writes in order src 110/100/010, addrs 1/2/3, on consecutive cycles. busy drops after the third.
- Back-to-back FPU streaming: valid held for 4 cycles with data 0x1..0x4 → fpu_ready stays 1 and 4 consecutive writes occur with matching data.
- Illegal fmt: ALU fmt=11 accepted → no write, err_illegal_fmt=1 for exactly one cycle.
- Starvation (macro defined, STARVE_LIMIT=4): ALU full plus MEM valid every cycle → ALU granted within 6 cycles. Macro undefined → ALU never granted while MEM streams.
